// File: rtl/arb3_mux_ctrl.sv
// Round-robin arbiter for three requesters sharing one WIDTH-bit output bus.
// One-hot grant doubles as mux select; the selected word is registered and handed off via valid/ready.
module arb3_mux_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             out_ready,
  output logic [2:0]       gnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       ack
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       winner;

  // Search starts just after the last-served requester and wraps around to it.
  function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [2:0] r);
    logic [2:0] w;
    w = 3'b000;
    case (last)
      3'b001: begin
        if (r[1])      w = 3'b010;
        else if (r[2]) w = 3'b100;
        else if (r[0]) w = 3'b001;
      end
      3'b010: begin
        if (r[2])      w = 3'b100;
        else if (r[0]) w = 3'b001;
        else if (r[1]) w = 3'b010;
      end
      default: begin
        if (r[0])      w = 3'b001;
        else if (r[1]) w = 3'b010;
        else if (r[2]) w = 3'b100;
      end
    endcase
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] sel_word(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] w;
    w = '0;
    case (sel)
      3'b001:  w = a;
      3'b010:  w = b;
      3'b100:  w = c;
      default: w = '0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 3'b100;
      gnt_q   <= 3'b000;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    winner  = 3'b000;
    case (state_q)
      IDLE: begin
        winner = rr_pick(last_q, req);
        if (|winner) begin
          state_d = GRANT;
          gnt_d   = winner;
          valid_d = 1'b1;
          data_d  = sel_word(winner, d0, d1, d2);
        end
      end
      GRANT: begin
        if (out_ready) begin
          // Transfer: advance pointer and re-arbitrate with the served requester masked.
          last_d = gnt_q;
          winner = rr_pick(gnt_q, req & ~gnt_q);
          if (|winner) begin
            gnt_d  = winner;
            data_d = sel_word(winner, d0, d1, d2);
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            valid_d = 1'b0;
          end
        end else if (~|(req & gnt_q)) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        valid_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ack       = gnt_q & {3{valid_q & out_ready}};

endmodule

// File: tb/tb_arb3_mux_ctrl.sv
// Scoreboard bench for arb3_mux_ctrl: directed scenarios plus randomized traffic
// checked per cycle against an index-based round-robin model.
module tb_arb3_mux_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [2:0]   req = 3'b000;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic         out_ready = 1'b0;
  logic [2:0]   gnt;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   ack;

  arb3_mux_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .out_ready (out_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   gnt;
    logic         valid;
    logic [W-1:0] data;
    logic [2:0]   ack;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: busy flag, index of granted requester, index of last served.
  bit         m_busy;
  int         m_cur;
  int         m_last;
  logic [W-1:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  function automatic int pick(input int l, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(l + k) % 3]) return (l + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return 3'(1 << i);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_cur  = 0;
    m_last = 2;
    m_data = '0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic rdy);
    logic [W-1:0] dv [3];
    logic [2:0]   rm;
    int           w;
    dv[0] = a; dv[1] = b; dv[2] = c;
    if (!m_busy) begin
      w = pick(m_last, r);
      if (w >= 0) begin
        m_busy = 1'b1; m_cur = w; m_data = dv[w];
      end
    end else if (rdy) begin
      m_last = m_cur;
      rm = r;
      rm[m_cur] = 1'b0;
      w = pick(m_cur, rm);
      if (w >= 0) begin
        m_cur = w; m_data = dv[w];
      end else begin
        m_busy = 1'b0;
      end
    end else if (!r[m_cur]) begin
      m_busy = 1'b0;
    end
  endtask

  // Apply inputs for one cycle, queue the expected outputs, advance the model at the edge.
  task automatic cycle(input logic [2:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic rdy);
    exp_t e;
    req = r; d0 = a; d1 = b; d2 = c; out_ready = rdy;
    e.gnt   = m_busy ? onehot(m_cur) : 3'b000;
    e.valid = m_busy;
    e.data  = m_data;
    e.ack   = (m_busy && rdy) ? onehot(m_cur) : 3'b000;
    expq.push_back(e);
    @(posedge clk);
    model_step(r, a, b, c, rdy);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"},   32'(gnt),       32'd0);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_data"},  32'(out_data),  32'd0);
    chk({nm, "_ack"},   32'(ack),       32'd0);
  endtask

  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    #1;
    chk_zero(nm);
    model_reset();
    expq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the queued expectation each cycle.
  always @(negedge clk) begin
    if (reset_n && expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("mon_gnt",   32'(gnt),       32'(mon_e.gnt));
      chk("mon_valid", 32'(out_valid), 32'(mon_e.valid));
      if (mon_e.valid) chk("mon_data", 32'(out_data), 32'(mon_e.data));
      chk("mon_ack",   32'(ack),       32'(mon_e.ack));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   r_req;
    logic [W-1:0] r_d [3];
    logic         rdy;
    logic [2:0]   ackv;
    logic [2:0]   rr_g [4];
    logic [W-1:0] rr_d [4];

    model_reset();
    req = 3'b111;
    #1;
    do_reset("reset");

    // Single requester: one word every two cycles.
    cycle(3'b001, 4'd1, 4'd0, 4'd0, 1'b1);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_data", 32'(out_data), 32'h1);
    cycle(3'b001, 4'd1, 4'd0, 4'd0, 1'b1);
    chk("single_bubble", 32'(out_valid), 32'h0);
    cycle(3'b001, 4'd1, 4'd0, 4'd0, 1'b1);
    chk("single_regrant", 32'(gnt), 32'h1);
    cycle(3'b000, 4'd1, 4'd0, 4'd0, 1'b1);
    cycle(3'b000, 4'd1, 4'd0, 4'd0, 1'b1);

    // Round-robin from reset pointer.
    do_reset("rr_reset");
    rr_g[0] = 3'b001; rr_g[1] = 3'b010; rr_g[2] = 3'b100; rr_g[3] = 3'b001;
    rr_d[0] = 4'd1;   rr_d[1] = 4'd2;   rr_d[2] = 4'd4;   rr_d[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
      chk("rr_gnt", 32'(gnt), 32'(rr_g[i]));
      chk("rr_data", 32'(out_data), 32'(rr_d[i]));
    end

    // Backpressure on requester 1.
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b0);
      chk("bp_gnt", 32'(gnt), 32'h2);
      chk("bp_data", 32'(out_data), 32'h2);
    end
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
    chk("pre_wd_gnt", 32'(gnt), 32'h2);

    // Withdrawal of granted requester 1 leaves the pointer alone.
    cycle(3'b101, 4'd1, 4'd2, 4'd4, 1'b0);
    chk("wd_gnt", 32'(gnt), 32'h0);
    chk("wd_valid", 32'(out_valid), 32'h0);
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b0);
    chk("wd_regrant", 32'(gnt), 32'h2);
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);

    // Mid-transfer reset drops the word and restarts from requester 0.
    do_reset("midreset");
    cycle(3'b111, 4'd1, 4'd2, 4'd4, 1'b1);
    chk("midreset_gnt", 32'(gnt), 32'h1);

    // Randomized traffic honouring the hold-until-ack rule, with occasional withdrawals.
    r_req = 3'b000;
    for (int i = 0; i < 3; i++) r_d[i] = W'($urandom);
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        if (!r_req[i]) begin
          r_d[i] = W'($urandom);
          if ($urandom_range(0, 2) == 0) r_req[i] = 1'b1;
        end else if ($urandom_range(0, 19) == 0) begin
          r_req[i] = 1'b0;
        end
      end
      ackv = (m_busy && rdy) ? onehot(m_cur) : 3'b000;
      cycle(r_req, r_d[0], r_d[1], r_d[2], rdy);
      for (int i = 0; i < 3; i++) begin
        if (ackv[i]) begin
          r_req[i] = 1'($urandom_range(0, 1));
          r_d[i]   = W'($urandom);
        end
      end
    end

    @(negedge clk);
    if (expq.size() != 0) chk("queue_drain", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
